// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and helpers for the FFT output serializer
package fft_pkg;

  localparam int unsigned N_DEFAULT   = 16;
  localparam int unsigned MSB_DEFAULT = 16;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } ser_state_t;

  // Counter width for an N-point frame; kept at least 1 bit wide.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Each sample is {imag, real}, both halves of equal width.
  function automatic int unsigned field_width(input int unsigned msb);
    return msb / 2;
  endfunction

endpackage

// File: rtl/fft_out_serializer.sv
// rtl/fft_out_serializer.sv - captures the parallel FFT result and streams it one sample per beat
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int N   = 16,
  parameter int MSB = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*MSB-1:0]     fft_data_in,
  input  logic                 calc_finish,
  output logic [MSB-1:0]       out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_index,
  output logic                 out_last,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam int IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  ser_state_t       state;
  ser_state_t       state_next;
  logic [N*MSB-1:0] buffer;

  logic accept;
  logic last_accept;
  logic capture;
  logic drop;

  assign accept      = (state == S_SEND) && out_ready;
  assign last_accept = accept && (out_index == LAST_IDX);
  // A new frame is taken when idle, or exactly as the final beat leaves.
  assign capture     = calc_finish && ((state == S_IDLE) || last_accept);
  assign drop        = calc_finish && (state == S_SEND) && !last_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (capture) begin
          state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (last_accept && !calc_finish) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    if (state == S_SEND) begin
      out_valid = 1'b1;
      busy      = 1'b1;
      out_last  = (out_index == LAST_IDX);
      out_data  = buffer[out_index*MSB +: MSB];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buffer     <= '0;
      out_index  <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= last_accept;
      if (drop) begin
        overrun <= 1'b1;
      end
      if (capture) begin
        buffer    <= fft_data_in;
        out_index <= '0;
      end else if (accept && (out_index != LAST_IDX)) begin
        out_index <= out_index + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_out_serializer.sv
// tb/tb_fft_out_serializer.sv - scoreboard bench for fft_out_serializer
module tb_fft_out_serializer;

  localparam int N     = 16;
  localparam int MSB   = 16;
  localparam int IDX_W = $clog2(N);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N*MSB-1:0]     fft_data_in;
  logic                 calc_finish;
  logic [MSB-1:0]       out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [IDX_W-1:0]     out_index;
  logic                 out_last;
  logic                 busy;
  logic                 frame_done;
  logic                 overrun;

  always #5 clk = ~clk;

  fft_out_serializer #(.N(N), .MSB(MSB)) dut (
    .clk         (clk),
    .rst         (rst),
    .fft_data_in (fft_data_in),
    .calc_finish (calc_finish),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_index   (out_index),
    .out_last    (out_last),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  typedef struct {
    logic [MSB-1:0]   data;
    logic [IDX_W-1:0] idx;
  } exp_t;

  exp_t             q[$];
  logic [MSB-1:0]   frame[N];
  int               checks = 0;
  int               errors = 0;
  int               beats = 0;
  logic             fd_exp = 1'b0;
  logic             stall_prev = 1'b0;
  logic [MSB-1:0]   prev_data;
  logic [IDX_W-1:0] prev_idx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_frame(input bit push);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      fft_data_in[k*MSB +: MSB] = frame[k];
      if (push) begin
        e.data = frame[k];
        e.idx  = IDX_W'(k);
        q.push_back(e);
      end
    end
  endtask

  // Inputs are already set for this cycle; check at negedge, then advance.
  task automatic run_cycle();
    exp_t e;
    @(negedge clk);
    chk("frame_done", frame_done, fd_exp);
    fd_exp = 1'b0;
    if (rst) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_data", out_data, prev_data);
        chk("stall_index", out_index, prev_idx);
      end
      if (out_valid && q.size() == 0) begin
        chk("spurious_valid", out_valid, 1'b0);
      end else if (out_valid && out_ready) begin
        e = q.pop_front();
        chk("data", out_data, e.data);
        chk("index", out_index, e.idx);
        chk("last", out_last, e.idx == IDX_W'(N - 1));
        fd_exp = (e.idx == IDX_W'(N - 1));
        beats++;
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = out_index;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int mode);
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      out_ready = (mode == 0) ? 1'b1 : ((n % 3) == 0);
      run_cycle();
      n++;
    end
    chk("drain_left", q.size(), 0);
    out_ready = 1'b0;
    run_cycle();
  endtask

  task automatic run_until_beats(input int target);
    int n = 0;
    while (beats < target && n < 100) begin
      run_cycle();
      n++;
    end
    chk("beat_count", beats, target);
  endtask

  task automatic capture_frame(input bit push);
    set_frame(push);
    calc_finish = 1'b1;
    run_cycle();
    calc_finish = 1'b0;
  endtask

  initial begin
    int b0;
    rst         = 1'b1;
    calc_finish = 1'b0;
    out_ready   = 1'b0;
    fft_data_in = '0;
    @(posedge clk); #1;
    run_cycle();
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_index", out_index, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_data", out_data, 0);

    // Basic frame, continuous ready
    for (int k = 0; k < N; k++) frame[k] = 16'h0100 + 16'(k);
    out_ready = 1'b1;
    capture_frame(1);
    chk("latency_valid", out_valid, 1);
    chk("latency_busy", busy, 1);
    b0 = beats;
    drain(0);
    chk("basic_beats", beats - b0, N);
    chk("basic_busy_after", busy, 0);
    chk("basic_valid_after", out_valid, 0);

    // Backpressure 1,0,0
    for (int k = 0; k < N; k++) frame[k] = 16'hA000 + 16'(k * 3);
    capture_frame(1);
    drain(1);
    chk("bp_busy_after", busy, 0);

    // Back-to-back: new capture as beat N-1 is accepted
    for (int k = 0; k < N; k++) frame[k] = 16'hB000 + 16'(k);
    out_ready = 1'b1;
    capture_frame(1);
    b0 = beats;
    run_until_beats(b0 + N - 1);
    for (int k = 0; k < N; k++) frame[k] = MSB'($urandom);
    set_frame(1);
    calc_finish = 1'b1;
    run_cycle();
    calc_finish = 1'b0;
    chk("b2b_valid", out_valid, 1);
    chk("b2b_index", out_index, 0);
    chk("b2b_frame_done", frame_done, 1);
    chk("b2b_overrun", overrun, 0);
    chk("b2b_data0", out_data, frame[0]);
    drain(0);

    // Overrun: capture attempt at beat 5
    for (int k = 0; k < N; k++) frame[k] = 16'h2000 + 16'(k);
    out_ready = 1'b1;
    capture_frame(1);
    b0 = beats;
    run_until_beats(b0 + 5);
    for (int k = 0; k < N; k++) frame[k] = 16'hFFFF;
    set_frame(0);
    calc_finish = 1'b1;
    run_cycle();
    calc_finish = 1'b0;
    chk("overrun_set", overrun, 1);
    drain(0);
    chk("overrun_sticky", overrun, 1);
    chk("overrun_busy_after", busy, 0);

    // Reset mid-frame at beat 7
    for (int k = 0; k < N; k++) frame[k] = 16'h3000 + 16'(k);
    out_ready = 1'b1;
    capture_frame(1);
    b0 = beats;
    run_until_beats(b0 + 7);
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_index", out_index, 0);
    for (int k = 0; k < N; k++) frame[k] = 16'h4000 + 16'(k * 5);
    capture_frame(1);
    chk("restart_index", out_index, 0);
    chk("restart_data0", out_data, frame[0]);
    drain(0);

    // Reset wins over a simultaneous capture
    for (int k = 0; k < N; k++) frame[k] = 16'h5000 + 16'(k);
    set_frame(0);
    rst = 1'b1;
    calc_finish = 1'b1;
    run_cycle();
    rst = 1'b0;
    calc_finish = 1'b0;
    chk("rstprio_valid", out_valid, 0);
    run_cycle();
    run_cycle();
    chk("rstprio_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_out_serializer.md
Name: fft_out_serializer

Overview:
- Read-side counterpart of the FFT register stage.
- Captures the N-sample parallel result bus when the FFT signals completion.
- Streams the samples out one per beat, in natural index order, over a valid/ready handshake.
- Sits between the FFT stage output and the downstream serial consumer (output formatter / UART TX path).

Parameters:
- N, 16: FFT points per frame; power of two, N >= 4.
- MSB, 16: bits per sample; packed {imag[MSB/2-1:0], real[MSB/2-1:0]}, as produced by the FFT stage.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- fft_data_in  input  N*MSB  parallel FFT result; sample k at bits [k*MSB +: MSB].
- calc_finish  input  1  one-cycle pulse: fft_data_in is valid this cycle.
- out_data  output  MSB  current sample.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready.
- out_index  output  $clog2(N)  index of the current sample.
- out_last  output  1  high with sample N-1.
- busy  output  1  frame held and not fully sent.
- frame_done  output  1  one-cycle pulse after sample N-1 is accepted.
- overrun  output  1  sticky: calc_finish arrived while busy and was dropped.

Behaviour:
- One clock, synchronous active-high reset. Reset is exactly as stated in the interface: port rst, synchronous, active-high.
- Reset values: out_valid=0, out_index=0, out_last=0, busy=0, frame_done=0, overrun=0, out_data=0. State is IDLE.
- Frame buffer: N*MSB register, loaded only on an accepted capture.

FSM, two states:
- IDLE:
  - calc_finish=1 -> capture fft_data_in, index=0, go to SEND.
  - Next cycle: out_valid=1, out_data=sample 0. Latency is 1 cycle from the calc_finish pulse.
- SEND:
  - out_data = buffer[index*MSB +: MSB]; out_valid=1; busy=1.
  - out_last = (index==N-1).
  - Beat accepted, index<N-1 -> index+1.
  - Beat accepted, index==N-1 -> frame_done pulses next cycle.
    - If calc_finish is not high that same cycle: go to IDLE and drop out_valid.
  - out_ready=0 -> hold out_data and out_index stable. A valid beat is never withdrawn.

Boundary conditions:
- calc_finish in SEND, not coinciding with the last accepted beat:
  - Frame ignored; buffer unchanged; overrun set (sticky until rst).
- calc_finish in the same cycle the last beat is accepted:
  - Back-to-back frame: capture the new data, index=0, stay in SEND, no gap cycle, no overrun.
  - frame_done still pulses for the old frame.
- out_ready held high continuously: N beats in N consecutive cycles. Throughput is 1 sample/cycle.
- Index wrap: the counter never increments past N-1; it reloads to 0 only on capture.
- rst mid-frame: the next cycle shows out_valid=0, index=0, IDLE, overrun=0. The partial frame is discarded with no frame_done.
- rst and calc_finish in the same cycle: rst wins; nothing is captured.
- Width: all widths derive from N and MSB. No truncation or sign handling; samples pass bit-exact.

Decomposition:
- Shared package fft_pkg:
  - IDX_W = $clog2(N).
  - Serializer state encoding (S_IDLE, S_SEND).
  - Sample field helpers: real/imag slice widths MSB/2.
- No sub-module. Buffer, counter and mux are trivial in one module; the N:1 sample mux is an indexed part-select.

Test Plan:
- Basic frame: N=16, MSB=16, sample k = 16'h0100+k, calc_finish pulse, out_ready=1 -> 16 beats on consecutive cycles, out_data 0x0100..0x010F, out_index 0..15, out_last only on beat 15, frame_done one cycle after beat 15, busy low afterwards.
- Backpressure: out_ready toggles 1,0,0,1,... -> out_data and out_index stable while stalled, no sample skipped or repeated, all 16 delivered in order.
- Overrun: second calc_finish (data 16'hFFFF) at beat 5 of a frame -> the first frame completes unchanged, overrun=1 and stays 1 until rst.
- Back-to-back: second calc_finish coincident with acceptance of beat 15 -> the next cycle shows out_valid=1, out_index=0 with the new frame's sample 0, frame_done=1, overrun=0.
- Reset mid-frame: rst at beat 7 -> the next cycle shows out_valid=0, busy=0, overrun=0. A following calc_finish restarts at index 0 with new data.
- Reset priority: rst and calc_finish in the same cycle -> no capture, out_valid stays 0.
